// File: rtl/csa_5_to_2_div_2.sv
// Five-operand carry-save compressor (three 3:2 rows) with a halving, registered sum/carry output.
// Build macro CSA_5_TO_2_ODD_FLAG_EN adds a registered "odd" flag carrying the parity of the sum.
module csa_5_to_2_div_2 #(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         en,
  input  logic [K-1:0] x1,
  input  logic [K-1:0] x2,
  input  logic [K-1:0] x3,
  input  logic [K-1:0] x4,
  input  logic [K-1:0] x5,
  output logic [K-1:0] s0,
  output logic [K-1:0] s1
`ifdef CSA_5_TO_2_ODD_FLAG_EN
  ,
  output logic         odd
`endif
);

  // Three guard bits hold the full five-operand sum, so cs+cc is exact.
  localparam int W = K + 3;

  function automatic logic [W-1:0] maj(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic [W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [W-1:0] e1, e2, e3, e4, e5;
  logic [W-1:0] as, ac, bs, bc, cs, cc;
  logic [K-1:0] n0, n1;
  logic [K-1:0] s0_q, s0_d, s1_q, s1_d;
  logic         unused_bits;

  assign e1 = {3'b000, x1};
  assign e2 = {3'b000, x2};
  assign e3 = {3'b000, x3};
  assign e4 = {3'b000, x4};
  assign e5 = {3'b000, x5};

  assign as = e1 ^ e2 ^ e3;
  assign ac = maj(e1, e2, e3) << 1;
  assign bs = as ^ ac ^ e4;
  assign bc = maj(as, ac, e4) << 1;
  assign cs = bs ^ bc ^ e5;
  assign cc = maj(bs, bc, e5) << 1;

  // cc[0] is structurally zero, so dropping bit 0 of both vectors halves the sum.
  assign n0 = cs[K:1];
  assign n1 = cc[K:1];

  always_comb begin
    // NOTE: next-state defaults to the current value first; without it the hold paths would infer latches.
    s0_d = s0_q;
    s1_d = s1_q;
    if (ce) begin
      if (clr) begin
        s0_d = '0;
        s1_d = '0;
      end else if (en) begin
        s0_d = n0;
        s1_d = n1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign s0 = s0_q;
  assign s1 = s1_q;

`ifdef CSA_5_TO_2_ODD_FLAG_EN
  logic odd_q, odd_d;

  always_comb begin
    odd_d = odd_q;
    if (ce) begin
      if (clr)     odd_d = 1'b0;
      else if (en) odd_d = cs[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) odd_q <= 1'b0;
    else     odd_q <= odd_d;
  end

  assign odd = odd_q;
  assign unused_bits = ^{cs[W-1:K+1], cc[W-1:K+1], cc[0]};
`else
  assign unused_bits = ^{cs[W-1:K+1], cc[W-1:K+1], cc[0], cs[0]};
`endif

endmodule

// File: tb/tb_csa_5_to_2_div_2.sv
// Self-checking bench for csa_5_to_2_div_2: directed tests at K=8 plus a scoreboard-driven random
// regression on K=8 and K=32 instances sharing the same control signals.
module tb_csa_5_to_2_div_2;

  logic        clk = 1'b0;
  logic        rst, ce, clr, en;
  logic [7:0]  a1, a2, a3, a4, a5;
  logic [31:0] b1, b2, b3, b4, b5;
  logic [7:0]  s0_8, s1_8;
  logic [31:0] s0_32, s1_32;
`ifdef CSA_5_TO_2_ODD_FLAG_EN
  logic        odd_8, odd_32;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  half8;
    logic [31:0] half32;
    logic        par8;
    logic        par32;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  csa_5_to_2_div_2 #(.K(8)) dut8 (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .en(en),
    .x1(a1), .x2(a2), .x3(a3), .x4(a4), .x5(a5),
    .s0(s0_8), .s1(s1_8)
`ifdef CSA_5_TO_2_ODD_FLAG_EN
    , .odd(odd_8)
`endif
  );

  csa_5_to_2_div_2 #(.K(32)) dut32 (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .en(en),
    .x1(b1), .x2(b2), .x3(b3), .x4(b4), .x5(b5),
    .s0(s0_32), .s1(s1_32)
`ifdef CSA_5_TO_2_ODD_FLAG_EN
    , .odd(odd_32)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] v1, v2, v3, v4, v5);
    a1 = v1; a2 = v2; a3 = v3; a4 = v4; a5 = v5;
    b1 = {24'd0, v1}; b2 = {24'd0, v2}; b3 = {24'd0, v3}; b4 = {24'd0, v4}; b5 = {24'd0, v5};
  endtask

  task automatic expect8(input string name, input logic [7:0] e0, input logic [7:0] e1);
    checks++;
    if (s0_8 !== e0 || s1_8 !== e1) begin
      errors++;
      $display("FAIL %s: got s0=%0d s1=%0d, expected s0=%0d s1=%0d", name, s0_8, s1_8, e0, e1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; clr = 1'b0; en = 1'b0;
    set_ops(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) tick();
    expect8("reset_held", 8'd0, 8'd0);
    #2 rst = 1'b0;
    ce = 1'b1;
    tick();
    expect8("reset_released", 8'd0, 8'd0);
    checks++;
    if (s0_32 !== 32'd0 || s1_32 !== 32'd0) begin
      errors++;
      $display("FAIL reset_k32: got s0=%0h s1=%0h, expected 0 0", s0_32, s1_32);
    end
`ifdef CSA_5_TO_2_ODD_FLAG_EN
    checks++;
    if (odd_8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_odd: got %b expected 0", odd_8);
    end
`endif
  endtask

  task automatic test_load();
    set_ops(8'd5, 8'd5, 8'd5, 8'd5, 8'd4);
    en = 1'b1;
    tick();
    en = 1'b0;
    expect8("load", 8'd2, 8'd10);
    checks++;
    if (s0_32 !== 32'd2 || s1_32 !== 32'd10) begin
      errors++;
      $display("FAIL load_k32: got s0=%0d s1=%0d, expected 2 10", s0_32, s1_32);
    end
`ifdef CSA_5_TO_2_ODD_FLAG_EN
    checks++;
    if (odd_8 !== 1'b0) begin
      errors++;
      $display("FAIL load_odd: got %b expected 0", odd_8);
    end
`endif
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      expect8("hold", 8'd2, 8'd10);
    end
  endtask

  task automatic test_clear_priority();
    set_ops(8'd5, 8'd5, 8'd5, 8'd5, 8'd4);
    clr = 1'b1; en = 1'b1;
    tick();
    expect8("clr_beats_en", 8'd0, 8'd0);
    clr = 1'b0;
    tick();
    en = 1'b0;
    expect8("load_after_clr", 8'd2, 8'd10);
  endtask

  task automatic test_ce_gating();
    logic [7:0] sum8;
    set_ops(8'd1, 8'd2, 8'd3, 8'd4, 8'd6);
    ce = 1'b0; en = 1'b1;
    tick();
    expect8("ce_low_hold", 8'd2, 8'd10);
    clr = 1'b1;
    tick();
    expect8("ce_low_blocks_clr", 8'd2, 8'd10);
    clr = 1'b0; ce = 1'b1;
    tick();
    en = 1'b0;
    sum8 = s0_8 + s1_8;
    checks++;
    if (sum8 !== 8'd8) begin
      errors++;
      $display("FAIL ce_restore: got s0+s1=%0d, expected 8", sum8);
    end
  endtask

  task automatic test_async_reset();
    set_ops(8'd5, 8'd5, 8'd5, 8'd5, 8'd4);
    en = 1'b1;
    tick();
    en = 1'b0;
    expect8("pre_async_load", 8'd2, 8'd10);
    #2 rst = 1'b1;
    #1;
    expect8("async_reset_mid_cycle", 8'd0, 8'd0);
    en = 1'b1;
    tick();
    expect8("async_reset_held", 8'd0, 8'd0);
    en = 1'b0;
    #2 rst = 1'b0;
    tick();
    expect8("after_reset_idle", 8'd0, 8'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    expect8("resume_after_reset", 8'd2, 8'd10);
  endtask

  task automatic test_random(input int n);
    logic [63:0] sum8, sum32;
    logic [7:0]  got8;
    logic [31:0] got32;
    exp_t        e;
    en = 1'b1; ce = 1'b1; clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom); a4 = 8'($urandom); a5 = 8'($urandom);
      b1 = $urandom; b2 = $urandom; b3 = $urandom; b4 = $urandom; b5 = $urandom;
      sum8  = 64'(a1) + 64'(a2) + 64'(a3) + 64'(a4) + 64'(a5);
      sum32 = 64'(b1) + 64'(b2) + 64'(b3) + 64'(b4) + 64'(b5);
      e.half8  = 8'(sum8 >> 1);
      e.half32 = 32'(sum32 >> 1);
      e.par8   = sum8[0];
      e.par32  = sum32[0];
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      got8  = s0_8 + s1_8;
      got32 = s0_32 + s1_32;
      checks++;
      if (got8 !== e.half8) begin
        errors++;
        $display("FAIL rand_k8[%0d]: got s0+s1=%0d, expected %0d", i, got8, e.half8);
      end
      checks++;
      if (got32 !== e.half32) begin
        errors++;
        $display("FAIL rand_k32[%0d]: got s0+s1=%0h, expected %0h", i, got32, e.half32);
      end
`ifdef CSA_5_TO_2_ODD_FLAG_EN
      checks++;
      if (odd_8 !== e.par8 || odd_32 !== e.par32) begin
        errors++;
        $display("FAIL rand_odd[%0d]: got %b/%b, expected %b/%b", i, odd_8, odd_32, e.par8, e.par32);
      end
`endif
    end
    en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_clear_priority();
    test_ce_gating();
    test_async_reset();
    test_random(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_5_to_2_div_2.md
Name: csa_5_to_2_div_2

Overview:
- Carry-save reducer used in the Montgomery/RSA datapath.
- Compresses five K-bit operands into a redundant sum/carry pair through three cascaded 3:2 full-adder rows.
- Halves the result by a one-bit right shift of both vectors, then registers it.
- Outputs s0/s1 feed the next iteration's operands. They are never resolved to binary inside this block.

Parameters:
- K, 8, operand and output width in bits (K >= 2).

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous, active-high reset; clears output registers
- ce  in  1  clock enable; when 0 all synchronous actions are suppressed
- clr  in  1  synchronous clear of output registers (qualified by ce)
- en  in  1  load enable; captures new halved result (qualified by ce)
- x1  in  K  operand 1
- x2  in  K  operand 2
- x3  in  K  operand 3
- x4  in  K  operand 4
- x5  in  K  operand 5
- s0  out  K  registered halved sum vector
- s1  out  K  registered halved carry vector

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Combinational datapath, with internal vectors K+3 bits wide and zero-extended operands:
  - Row A: as = x1^x2^x3; ac = maj(x1,x2,x3)<<1.
  - Row B: bs = as^ac^x4; bc = maj(as,ac,x4)<<1.
  - Row C: cs = bs^bc^x5; cc = maj(bs,bc,x5)<<1.
  - Invariant: cs+cc = x1+x2+x3+x4+x5 exactly.
- Halving: n0 = cs[K:1], n1 = cc[K:1].
  - cc[0] is always 0, so n0+n1 = floor(sum/2) mod 2^K.
  - Bits above K are discarded. The caller guarantees the range in Montgomery use.
- Registers s0/s1, priority per rising clk edge:
  - rst=1 (async, any time): s0=0, s1=0 immediately, held while rst=1.
  - else ce=0: hold.
  - else clr=1: s0=0, s1=0 (clr beats en when both are high).
  - else en=1: s0<=n0, s1<=n1.
  - else: hold.
- Latency: 1 cycle from en sampled high to new s0/s1 visible. Throughput: one load per cycle with en held high.
- Outputs hold their value indefinitely while en=0 and clr=0; operand changes have no effect.
- Reset value of every output: 0.
- Reset deasserted mid-operation: the register resumes on the next qualified edge with no residual state. The block is purely register plus combinational logic and has no FSM.
- No X propagation from unused high bits; all internal extensions are zero-filled.

Optional Feature:
- Macro: CSA_5_TO_2_ODD_FLAG_EN.
- When defined:
  - Adds output port "odd" (1 bit), registered alongside s0/s1 with identical rst/ce/clr/en rules (reset 0).
  - Loaded with cs[0], i.e. parity of the five-operand sum.
  - odd=1 flags that the halving dropped a nonzero LSB, which is a Montgomery precondition violation.
- When undefined: port absent, no extra logic. s0/s1 behaviour is identical in both builds.

Test Plan:
- Reset: assert rst asynchronously between edges with s0/s1 nonzero -> s0=0, s1=0 before the next edge. Also check s0=s1=0 immediately after power-up reset.
- Load, K=8: x1..x4=5, x5=4, one-cycle en pulse, ce=1 -> after the edge s0=2, s1=10 (sum 12 = 24/2); odd=0 if enabled.
- Hold: after the load above, keep en=0 for 3 cycles while changing x1..x5 to random values -> s0=2, s1=10 unchanged.
- Clear priority: drive clr=1 and en=1 together with x1..x5=5,5,5,5,4 -> s0=0, s1=0. Then clr=0, en=1 -> s0=2, s1=10.
- ce gating: ce=0 with en=1 and new operands -> no change. Restore ce=1 -> load occurs on that edge.
- Random regression, 1000 vectors, K=8 and K=32: after each en load check (s0+s1) mod 2^K == floor((x1+...+x5)/2) mod 2^K. With the feature enabled, also check odd == parity of the sum.
